// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 access codes, FSM states and
// the access-size to byte-mask helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_D  = 3'b011,
    LS_BU = 3'b100,
    LS_HU = 3'b101,
    LS_WU = 3'b110
  } ls_funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, byte enables, replicated store data
// and shifted/extended load data. Zero latency, no flow control.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]               funct3_i,
  input  logic [2:0]               off_i,
  input  logic                     is_store_i,
  input  logic [XLEN-1:0]          st_data_i,
  input  logic [2:0]               ld_funct3_i,
  input  logic [$clog2(XLEN/8)-1:0] ld_off_i,
  input  logic [XLEN-1:0]          rdata_i,
  output logic                     err_o,
  output logic [XLEN/8-1:0]        be_o,
  output logic [XLEN-1:0]          wdata_o,
  output logic [XLEN-1:0]          ldata_o
);

  localparam int  NBYTES = XLEN / 8;
  localparam int  OFFW   = $clog2(NBYTES);
  localparam bit  IS64   = (XLEN == 64);

  logic [XLEN-1:0] shifted;

  always_comb begin
    err_o = 1'b0;
    case (funct3_i)
      LS_B, LS_BU: err_o = 1'b0;
      LS_H, LS_HU: err_o = off_i[0];
      LS_W:        err_o = |off_i[1:0];
      LS_WU:       err_o = !IS64 || is_store_i || (|off_i[1:0]);
      LS_D:        err_o = !IS64 || (|off_i[2:0]);
      default:     err_o = 1'b1;
    endcase
  end

  assign be_o = NBYTES'(size_mask(funct3_i[1:0])) << off_i[OFFW-1:0];

  always_comb begin
    wdata_o = st_data_i;
    case (funct3_i[1:0])
      2'd0:    wdata_o = {NBYTES{st_data_i[7:0]}};
      2'd1:    wdata_o = {(NBYTES/2){st_data_i[15:0]}};
      2'd2:    wdata_o = {(NBYTES/4){st_data_i[31:0]}};
      default: wdata_o = st_data_i;
    endcase
  end

  // Bring the addressed byte to lane 0, then truncate and extend.
  assign shifted = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ldata_o = shifted;
    case (ld_funct3_i)
      LS_B:    ldata_o = XLEN'($signed(shifted[7:0]));
      LS_H:    ldata_o = XLEN'($signed(shifted[15:0]));
      LS_W:    ldata_o = XLEN'($signed(shifted[31:0]));
      LS_BU:   ldata_o = XLEN'(shifted[7:0]);
      LS_HU:   ldata_o = XLEN'(shifted[15:0]);
      LS_WU:   ldata_o = XLEN'(shifted[31:0]);
      default: ldata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between IEU and data memory: one access at a time over req/gnt/rvalid,
// min load latency 3 cycles, passthrough 1 cycle; IEU is stalled while an access is in flight.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ieu_valid,
  input  logic                ieu_we,
  input  logic                ieu_re,
  input  logic                ieu_passthrough,
  input  logic [2:0]          ieu_funct3,
  input  logic [XLEN-1:0]     ieu_reg,
  input  logic [XLEN-1:0]     ieu_result,
  output logic                stall,
  output logic                access_err,
  output logic                data_req,
  input  logic                data_gnt,
  output logic                data_we,
  output logic [XLEN/8-1:0]   data_be,
  output logic [XLEN-1:0]     data_addr,
  output logic [XLEN-1:0]     data_out,
  input  logic                data_rvalid,
  input  logic [XLEN-1:0]     data_in,
  output logic                rd_valid,
  output logic [XLEN-1:0]     rd_data
);

  localparam int NBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(NBYTES);

  lsu_state_t        state_q;
  logic              data_req_q, data_we_q, rd_valid_q, access_err_q;
  logic [NBYTES-1:0] data_be_q;
  logic [XLEN-1:0]   data_addr_q, data_out_q, rd_data_q;
  logic [2:0]        ld_f3_q;
  logic [OFFW-1:0]   ld_off_q;

  logic              err_d;
  logic [NBYTES-1:0] be_d;
  logic [XLEN-1:0]   wdata_d, ldata_d;
  logic              mem_op, accept_mem;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i    (ieu_funct3),
    .off_i       (ieu_result[2:0]),
    .is_store_i  (ieu_we),
    .st_data_i   (ieu_reg),
    .ld_funct3_i (ld_f3_q),
    .ld_off_i    (ld_off_q),
    .rdata_i     (data_in),
    .err_o       (err_d),
    .be_o        (be_d),
    .wdata_o     (wdata_d),
    .ldata_o     (ldata_d)
  );

  assign mem_op     = ieu_valid && !ieu_passthrough && (ieu_we || ieu_re);
  assign accept_mem = mem_op && !err_d;
  assign stall      = (state_q != IDLE) || accept_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= '0;
      data_addr_q  <= '0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      access_err_q <= 1'b0;
      ld_f3_q      <= '0;
      ld_off_q     <= '0;
    end else begin
      rd_valid_q   <= 1'b0;
      access_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ieu_valid && ieu_passthrough) begin
            rd_data_q  <= ieu_result;
            rd_valid_q <= 1'b1;
          end else if (mem_op && err_d) begin
            access_err_q <= 1'b1;
          end else if (accept_mem) begin
            state_q     <= REQ;
            data_req_q  <= 1'b1;
            data_we_q   <= ieu_we;
            data_be_q   <= be_d;
            data_addr_q <= {ieu_result[XLEN-1:OFFW], {OFFW{1'b0}}};
            data_out_q  <= wdata_d;
            ld_f3_q     <= ieu_funct3;
            ld_off_q    <= ieu_result[OFFW-1:0];
          end
        end
        REQ: begin
          if (data_gnt) begin
            data_req_q <= 1'b0;
            state_q    <= data_we_q ? IDLE : WAIT;
          end
        end
        // rvalid is only honoured here, so one arriving alongside gnt is not counted.
        WAIT: begin
          if (data_rvalid) begin
            rd_data_q  <= ldata_d;
            rd_valid_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_req   = data_req_q;
  assign data_we    = data_we_q;
  assign data_be    = data_be_q;
  assign data_addr  = data_addr_q;
  assign data_out   = data_out_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed + randomized bench for lsu (XLEN=32) against a byte-level reference model.
module tb_lsu;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ieu_valid, ieu_we, ieu_re, ieu_passthrough;
  logic [2:0]        ieu_funct3;
  logic [XLEN-1:0]   ieu_reg, ieu_result;
  logic              stall, access_err, data_req, data_gnt, data_we;
  logic [XLEN/8-1:0] data_be;
  logic [XLEN-1:0]   data_addr, data_out, data_in, rd_data;
  logic              data_rvalid, rd_valid;

  int checks   = 0;
  int failures = 0;

  lsu #(.XLEN(XLEN)) dut (
    .clk             (clk),
    .rst             (rst),
    .ieu_valid       (ieu_valid),
    .ieu_we          (ieu_we),
    .ieu_re          (ieu_re),
    .ieu_passthrough (ieu_passthrough),
    .ieu_funct3      (ieu_funct3),
    .ieu_reg         (ieu_reg),
    .ieu_result      (ieu_result),
    .stall           (stall),
    .access_err      (access_err),
    .data_req        (data_req),
    .data_gnt        (data_gnt),
    .data_we         (data_we),
    .data_be         (data_be),
    .data_addr       (data_addr),
    .data_out        (data_out),
    .data_rvalid     (data_rvalid),
    .data_in         (data_in),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the access rules in terms of byte counts.
  function automatic bit m_legal(input bit [2:0] f3, input bit st, input logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    if (f3 == 3'd7) return 1'b0;
    if (sz > XLEN / 8) return 1'b0;
    if (f3 == 3'd6 && (st || XLEN != 64)) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] m_be(input bit [2:0] f3, input logic [31:0] a);
    int sz, off;
    logic [31:0] r;
    sz = 1 << f3[1:0];
    off = a % 4;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + sz);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input bit [2:0] f3, input logic [31:0] wd);
    int sz;
    logic [31:0] r;
    sz = 1 << f3[1:0];
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input bit [2:0] f3, input logic [31:0] a, input logic [31:0] din);
    int sz, off;
    longint unsigned v;
    sz = 1 << f3[1:0];
    off = a % 4;
    v = 0;
    for (int i = 0; i < sz; i++) v = v + (longint'(din[8*(off+i) +: 8]) << (8*i));
    if (f3 < 3'd4 && v >= (64'd1 << (8*sz - 1))) v = v + ~((64'd1 << (8*sz)) - 1);
    return v[31:0];
  endfunction

  // Issues one op starting just after a clock edge and runs it to completion.
  task automatic do_op(input bit pt, input bit we, input bit re, input bit [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] din,
                       input int gw, input int rw);
    bit st, ld, ok;
    st = !pt && we;
    ld = !pt && !we && re;
    ok = (st || ld) && m_legal(f3, st, addr);
    ieu_valid = 1'b1; ieu_passthrough = pt; ieu_we = we; ieu_re = re;
    ieu_funct3 = f3; ieu_result = addr; ieu_reg = wd;
    #1 chk("stall_at_accept", stall, ok);
    @(posedge clk); #1;
    ieu_valid = 1'b0;
    if (pt) begin
      chk("pt_rd_valid", rd_valid, 1'b1);
      chk("pt_rd_data", rd_data, addr);
      chk("pt_no_req", data_req, 1'b0);
      @(posedge clk); #1;
      chk("pt_rd_valid_pulse", rd_valid, 1'b0);
      return;
    end
    if (!st && !ld) begin
      chk("noop_no_req", data_req, 1'b0);
      chk("noop_no_err", access_err, 1'b0);
      chk("noop_no_rd", rd_valid, 1'b0);
      return;
    end
    if (!ok) begin
      chk("err_pulse", access_err, 1'b1);
      chk("err_no_req", data_req, 1'b0);
      chk("err_no_stall", stall, 1'b0);
      chk("err_no_rd", rd_valid, 1'b0);
      @(posedge clk); #1;
      chk("err_pulse_end", access_err, 1'b0);
      chk("err_still_no_req", data_req, 1'b0);
      return;
    end
    chk("req", data_req, 1'b1);
    chk("req_we", data_we, st);
    chk("req_addr", data_addr, addr & ~32'h3);
    chk("req_be", data_be, m_be(f3, addr));
    if (st) chk("req_wdata", data_out, m_wdata(f3, wd));
    for (int k = 0; k < gw; k++) begin
      @(posedge clk); #1;
      chk("req_held", data_req, 1'b1);
      chk("req_addr_held", data_addr, addr & ~32'h3);
      chk("req_be_held", data_be, m_be(f3, addr));
      chk("stall_in_req", stall, 1'b1);
    end
    data_gnt = 1'b1;
    data_rvalid = ld ? 1'($urandom_range(0, 1)) : 1'b0;
    data_in = $urandom;
    @(posedge clk); #1;
    data_gnt = 1'b0;
    data_rvalid = 1'b0;
    chk("req_dropped", data_req, 1'b0);
    chk("no_rd_after_gnt", rd_valid, 1'b0);
    if (st) begin
      chk("store_stall_low", stall, 1'b0);
      return;
    end
    chk("stall_in_wait", stall, 1'b1);
    for (int k = 0; k < rw; k++) begin
      @(posedge clk); #1;
      chk("wait_no_rd", rd_valid, 1'b0);
    end
    data_rvalid = 1'b1;
    data_in = din;
    @(posedge clk); #1;
    data_rvalid = 1'b0;
    data_in = $urandom;
    chk("load_rd_valid", rd_valid, 1'b1);
    chk("load_rd_data", rd_data, m_load(f3, addr, din));
    chk("load_stall_low", stall, 1'b0);
    @(posedge clk); #1;
    chk("load_rd_valid_pulse", rd_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ieu_valid = 1'b0; ieu_we = 1'b0; ieu_re = 1'b0; ieu_passthrough = 1'b0;
    ieu_funct3 = 3'd0; ieu_reg = '0; ieu_result = '0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", data_req, 1'b0);
    chk("rst_we", data_we, 1'b0);
    chk("rst_be", data_be, 4'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_out", data_out, 32'h0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_err", access_err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 1, 0, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 0);
    do_op(0, 0, 1, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 2);
    chk("lh_value", rd_data, 32'hFFFF_8001);
    do_op(0, 0, 1, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_F000, 0, 0);
    chk("lbu_value", rd_data, 32'h0000_00F0);
    do_op(0, 0, 1, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_F000, 1, 1);
    chk("lb_value", rd_data, 32'hFFFF_FFF0);
    do_op(0, 1, 0, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 0, 0);
    chk("rd_data_holds", rd_data, 32'hFFFF_FFF0);
    do_op(0, 0, 1, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 0, 0);
    do_op(0, 0, 1, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
    do_op(0, 0, 1, 3'b110, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
    do_op(0, 1, 0, 3'b111, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
    do_op(0, 1, 0, 3'b101, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
    do_op(0, 0, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 0, 0);

    // Passthrough immediately followed by a store.
    ieu_valid = 1'b1; ieu_passthrough = 1'b1; ieu_we = 1'b1; ieu_re = 1'b0;
    ieu_funct3 = 3'b010; ieu_result = 32'h1234_5678; ieu_reg = 32'h0;
    #1 chk("b2b_pt_no_stall", stall, 1'b0);
    @(posedge clk); #1;
    chk("b2b_pt_rd_valid", rd_valid, 1'b1);
    chk("b2b_pt_rd_data", rd_data, 32'h1234_5678);
    chk("b2b_pt_no_req", data_req, 1'b0);
    ieu_passthrough = 1'b0; ieu_result = 32'h0000_4000; ieu_reg = 32'h1122_3344;
    #1 chk("b2b_st_stall", stall, 1'b1);
    @(posedge clk); #1;
    ieu_valid = 1'b0;
    chk("b2b_st_req", data_req, 1'b1);
    chk("b2b_st_addr", data_addr, 32'h0000_4000);
    chk("b2b_st_be", data_be, 4'hF);
    chk("b2b_st_out", data_out, 32'h1122_3344);
    chk("b2b_rd_valid_pulse", rd_valid, 1'b0);
    data_gnt = 1'b1;
    @(posedge clk); #1;
    data_gnt = 1'b0;
    chk("b2b_st_done", data_req, 1'b0);

    // Reset while waiting for load data; the late rvalid must be dropped.
    ieu_valid = 1'b1; ieu_passthrough = 1'b0; ieu_we = 1'b0; ieu_re = 1'b1;
    ieu_funct3 = 3'b010; ieu_result = 32'h0000_5000;
    @(posedge clk); #1;
    ieu_valid = 1'b0;
    chk("rw_req", data_req, 1'b1);
    data_gnt = 1'b1;
    @(posedge clk); #1;
    data_gnt = 1'b0;
    chk("rw_in_wait", stall, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rw_req_low", data_req, 1'b0);
    chk("rw_rd_valid_low", rd_valid, 1'b0);
    chk("rw_idle", stall, 1'b0);
    data_rvalid = 1'b1; data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    data_rvalid = 1'b0;
    chk("rw_late_rvalid_ignored", rd_valid, 1'b0);
    chk("rw_late_rvalid_no_stall", stall, 1'b0);
    @(posedge clk); #1;
    chk("rw_late_rvalid_no_rd", rd_valid, 1'b0);
    do_op(0, 0, 1, 3'b010, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 0, 0);
    chk("rw_next_load", rd_data, 32'hCAFE_F00D);

    for (int n = 0; n < 80; n++) begin
      do_op(($urandom % 8) == 0, 1'($urandom), 1'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
